bias_seq_ctrl: RTL

Sequencer for a layer's bias ROM. On each `ap_start` it reads bias coefficients 0..KERN-1 from the synchronous bias ROM, repeating the sweep REPEAT times. It pushes every coefficient, in order, into the downstream FIFO write port using the `full_n`/`write` handshake. It sits between the per-layer bias `rom` instance and the accumulator input stream, and replaces a free-running bias source with an ap_ctrl-controlled one.

---
 rtl/bias_seq_ctrl_pkg.sv | 20 ++
 rtl/bias_seq_ctrl_if.sv | 36 +++
 rtl/bias_skid_buf.sv | 55 +++++
 rtl/bias_seq_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/bias_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the bias ROM sequencer slice.
package bias_seq_ctrl_pkg;

    localparam int COEFF_WIDTH    = 16;
    localparam int KERN_DEFAULT   = 16;
    localparam int REPEAT_DEFAULT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Counter width that stays legal (>=1) for a count of one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bias_seq_ctrl_if.sv
// ap_ctrl, bias ROM read port and output FIFO write port of the bias sequencer.
interface bias_seq_ctrl_if
    import bias_seq_ctrl_pkg::*;
#(
    parameter int COEFF_W = COEFF_WIDTH,
    parameter int ADDR_W  = 4
);
    logic               ap_start;
    logic               ap_done;
    logic               ap_idle;
    logic               ap_ready;
    logic [ADDR_W-1:0]  bias_V_address0;
    logic               bias_V_ce0;
    logic [COEFF_W-1:0] bias_V_q0;
    logic [COEFF_W-1:0] output_V_din;
    logic               output_V_full_n;
    logic               output_V_write;

    modport master (
        input  ap_start,
        output ap_done, ap_idle, ap_ready,
        output bias_V_address0, bias_V_ce0,
        input  bias_V_q0,
        output output_V_din, output_V_write,
        input  output_V_full_n
    );

    modport slave (
        output ap_start,
        input  ap_done, ap_idle, ap_ready,
        input  bias_V_address0, bias_V_ce0,
        output bias_V_q0,
        input  output_V_din, output_V_write,
        output output_V_full_n
    );
endinterface

// File: rtl/bias_skid_buf.sv
// Two-entry FIFO holding ROM results until the downstream FIFO accepts them.
module bias_skid_buf
    import bias_seq_ctrl_pkg::*;
#(
    parameter int COEFF_W = COEFF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [COEFF_W-1:0] din,
    output logic [COEFF_W-1:0] dout,
    output logic [1:0]         occ
);
    logic [COEFF_W-1:0] mem_r [2];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         occ_r;
    logic               push_s;
    logic               pop_s;

    // Qualify push/pop so the buffer never over- or under-runs.
    always_comb begin
        pop_s  = pop && (occ_r != 2'd0);
        push_s = push && ((occ_r != 2'd2) || pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign dout = mem_r[rd_ptr_r];
    assign occ  = occ_r;
endmodule

// File: rtl/bias_seq_ctrl.sv
// ap_ctrl-driven sequencer sweeping the bias ROM REPEAT times into a FIFO write port.
module bias_seq_ctrl
    import bias_seq_ctrl_pkg::*;
#(
    parameter int KERN    = KERN_DEFAULT,
    parameter int REPEAT  = REPEAT_DEFAULT,
    parameter int COEFF_W = COEFF_WIDTH,
    parameter int ADDR_W  = cnt_width(KERN)
) (
    input  logic           ap_clk,
    input  logic           ap_rst_n,
    bias_seq_ctrl_if.master io
);
    localparam int                REP_W     = cnt_width(REPEAT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(KERN - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT - 1);

    seq_state_e         state_r;
    seq_state_e         state_nxt_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [ADDR_W-1:0]  last_addr_r;
    logic [REP_W-1:0]   rep_r;
    logic               inflight_r;
    logic               idle_r;
    logic               done_r;
    logic [1:0]         occ_s;
    logic [COEFF_W-1:0] head_s;
    logic [2:0]         credit_s;
    logic               write_s;
    logic               issue_s;
    logic               last_issue_s;

    // Credit counts buffered plus in-flight data; a read may issue while it stays under two.
    always_comb begin
        write_s      = (occ_s != 2'd0) && io.output_V_full_n;
        credit_s     = {1'b0, occ_s} + {2'b00, inflight_r};
        issue_s      = (state_r == ST_RUN) && ((credit_s - {2'b00, write_s}) < 3'd2);
        last_issue_s = issue_s && (addr_r == ADDR_LAST) && (rep_r == REP_LAST);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (io.ap_start) state_nxt_s = ST_RUN;
                else             state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_issue_s) state_nxt_s = ST_DRAIN;
                else              state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!inflight_r && (occ_s == 2'd0)) state_nxt_s = ST_DONE;
                else                                state_nxt_s = ST_DRAIN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered ap_ctrl outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r <= ST_IDLE;
            idle_r  <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idle_r  <= (state_nxt_s == ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Sweep counters; last_addr_r keeps the ROM address stable between reads.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            addr_r      <= '0;
            rep_r       <= '0;
            last_addr_r <= '0;
            inflight_r  <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if ((state_r == ST_IDLE) && io.ap_start) begin
                addr_r <= '0;
                rep_r  <= '0;
            end else if (issue_s) begin
                last_addr_r <= addr_r;
                if (addr_r == ADDR_LAST) begin
                    addr_r <= '0;
                    rep_r  <= (rep_r == REP_LAST) ? '0 : rep_r + REP_W'(1);
                end else begin
                    addr_r <= addr_r + ADDR_W'(1);
                end
            end
        end
    end

    bias_skid_buf #(.COEFF_W(COEFF_W)) u_buf (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .push  (inflight_r),
        .pop   (write_s),
        .din   (io.bias_V_q0),
        .dout  (head_s),
        .occ   (occ_s)
    );

    assign io.ap_idle         = idle_r;
    assign io.ap_done         = done_r;
    assign io.ap_ready        = done_r;
    assign io.bias_V_ce0      = issue_s;
    assign io.bias_V_address0 = issue_s ? addr_r : last_addr_r;
    assign io.output_V_din    = head_s;
    assign io.output_V_write  = write_s;
endmodule
